control_unit_mc: RTL and testbench
==================================

Name: control_unit_mc

Overview:
- Multi-cycle successor to the single-cycle control decoder.
- Sequences every instruction through FETCH/DECODE/EXECUTE/MEM/WB, holds an internal NZCV flags register, and evaluates full ARM-style condition codes on all instruction classes.
- Handshakes with instruction and data memory, with an optional data-memory timeout.
- Sits between the external instruction register (which drives opcodes/operation/condicion) and the datapath muxes, register file, ALU and memory.

Parameters:
- COND_FULL, 1: 1 = all 16 condition codes on all classes. 0 = legacy mode: only branches are conditional, on EQ/NE only; every other code fails a branch, and non-branches always pass.
- FLAGS_RST, 4'b0000: NZCV value loaded on reset.
- MEM_TIMEOUT, 0: maximum cycles spent in MEM waiting for memReady. 0 = wait forever.
- TO_W, 8: timeout counter width. Requires MEM_TIMEOUT < 2**TO_W.

Ports:
- clk in 1 system clock
- rst in 1 synchronous active-high reset
- instrValid in 1 instruction memory data valid (sampled in FETCH)
- opcodes in 6 [5]=I, [4:1]=cmd, [0]=S (DP) / L (mem); [3]=U (mem); [4]=link (branch)
- operation in 2 00 DP, 01 mem, 10 branch, 11 undefined
- condicion in 4 condition code
- aluFlags in 4 ALU N,Z,C,V (bit3..0) for the current EXECUTE
- memReady in 1 data memory handshake complete
- irWr out 1 latch instruction register
- pcWr out 1 PC write enable
- selPC out 1 0 = PC+4, 1 = branch target
- regWe out 1 register file write (active-high)
- selAddA out 1 register A address mux select
- selAddB out 1 register B address mux select
- selAddWr out 1 1 = link register destination
- opALU out 4 ALU op
- cin out 1 ALU carry-in
- selDiWr out 2 00 ALU, 01 operand B, 10 memory, 11 PC+4
- selOperaB out 1 immediate operand select
- memReq out 1 data memory request
- memWe out 1 data memory write (store)
- logicalOperation out 1 current DP op is logical
- flags out 4 registered NZCV
- condPass out 1 registered condition result
- memErr out 1 sticky timeout error

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state=FETCH, flags=FLAGS_RST, condPass=0, memErr=0, timeout counter=0.
  - All strobes 0 (irWr, pcWr, regWe, memReq, memWe); opALU=0, selDiWr=00, all selects 0.
  - rst asserted in any state, including mid-MEM with memReq high, aborts the instruction; no write strobe is asserted in that cycle.
- Outputs are combinational from the current state and the opcode/operation inputs, which are stable from DECODE onward. Outside the listed states every strobe is 0.
- FETCH:
  - instrValid=0: hold; no strobes.
  - instrValid=1: irWr=1, pcWr=1, selPC=0 for one cycle, then go to DECODE.
- DECODE:
  - Register condPass from condicion and flags: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 0.
  - Next state: fail -> FETCH; operation=11 -> FETCH (NOP); else EXECUTE.
- EXECUTE, DP:
  - opALU=opcodes[4:1]; cin=1 only for cmd 0010; selOperaB=opcodes[5].
  - logicalOperation=1 for cmd 0000, 0001, 1000, 1001, 1100, 1101, 1110, 1111.
  - Flags update at the end of EXECUTE when S=1 or cmd=10xx. N and Z are always taken from aluFlags. C and V are taken from aluFlags only when the op is not logical; otherwise they are kept.
  - cmd=10xx (compare) -> FETCH; otherwise -> WB.
- EXECUTE, mem: selAddA=selAddB=1; opALU=0100 if U=1, else 0010; go to MEM.
- EXECUTE, branch:
  - pcWr=1, selPC=1.
  - If link=1: regWe=1, selAddWr=1, selDiWr=11, same cycle.
  - Go to FETCH.
- MEM:
  - memReq=1; memWe = !L; address mux selects held from EXECUTE.
  - memReady=1: load -> WB, store -> FETCH.
  - MEM_TIMEOUT>0: the counter increments each waiting cycle. When it reaches MEM_TIMEOUT with memReady=0, set memErr=1, drop memReq, make no register write, and go to FETCH.
  - memReady and timeout in the same cycle: memReady wins.
  - The counter clears on leaving MEM.
- WB:
  - regWe=1; go to FETCH.
  - selDiWr: 10 for load; 01 for DP cmd 1101; else 00.
- Cycle counts without stalls:
  - DP 4; compare 3; load 5; store 4; branch 3; condition-fail or undefined 2.
- Flags are written only in EXECUTE, so the next instruction's DECODE sees the updated flags.

Test Plan:
- rst, then DP ADD (op 00, cmd 0100, S=1, cond 1110), aluFlags=0011 -> 4 cycles; regWe only in WB; flags=0011 afterwards.
- CMP (cmd 1010) with aluFlags=0100, then BEQ with link=1 -> CMP takes 3 cycles with no regWe; branch EXECUTE has pcWr=1, selPC=1, regWe=1, selAddWr=1, selDiWr=11.
- flags=1000 (N=1, V=0), then GE DP op -> condPass=0; back to FETCH after DECODE; no regWe, memReq or flag change.
- LDR with memReady delayed 3 cycles -> memReq high 4 cycles, memWe=0; WB selDiWr=10; total 8 cycles.
- MEM_TIMEOUT=4, STR with memReady stuck at 0 -> memErr=1 after 4 MEM cycles; FETCH next; memErr stays 1 until rst.
- COND_FULL=0, DP with cond=1111 executes; branch with cond=1010 is not taken; rst asserted mid-MEM -> FETCH next cycle, all strobes 0, flags=FLAGS_RST.

Source files
------------

// File: rtl/control_unit_mc.sv
// rtl/control_unit_mc.sv - multi-cycle control unit: FETCH/DECODE/EXECUTE/MEM/WB sequencing,
// NZCV flags, condition evaluation and data-memory handshake with optional timeout.
module control_unit_mc #(
  parameter int         COND_FULL   = 1,
  parameter logic [3:0] FLAGS_RST   = 4'b0000,
  parameter int         MEM_TIMEOUT = 0,
  parameter int         TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instrValid,
  input  logic [5:0] opcodes,
  input  logic [1:0] operation,
  input  logic [3:0] condicion,
  input  logic [3:0] aluFlags,
  input  logic       memReady,
  output logic       irWr,
  output logic       pcWr,
  output logic       selPC,
  output logic       regWe,
  output logic       selAddA,
  output logic       selAddB,
  output logic       selAddWr,
  output logic [3:0] opALU,
  output logic       cin,
  output logic [1:0] selDiWr,
  output logic       selOperaB,
  output logic       memReq,
  output logic       memWe,
  output logic       logicalOperation,
  output logic [3:0] flags,
  output logic       condPass,
  output logic       memErr
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = (MEM_TIMEOUT > 0) ? TO_W'(MEM_TIMEOUT - 1) : '0;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_flags;
  logic            r_cond_pass;
  logic            r_mem_err;
  logic [TO_W-1:0] r_to_cnt;

  logic       w_is_dp;
  logic       w_is_mem;
  logic       w_is_br;
  logic       w_is_undef;
  logic [3:0] w_cmd;
  logic       w_load;
  logic       w_up;
  logic       w_link;
  logic       w_compare;
  logic       w_logical;
  logic       w_flag_upd;
  logic       w_cond_full;
  logic       w_cond_ok;
  logic       w_timeout;
  logic       w_n;
  logic       w_z;
  logic       w_c;
  logic       w_v;

  assign w_is_dp    = (operation == 2'b00);
  assign w_is_mem   = (operation == 2'b01);
  assign w_is_br    = (operation == 2'b10);
  assign w_is_undef = (operation == 2'b11);
  assign w_cmd      = opcodes[4:1];
  assign w_load     = opcodes[0];
  assign w_up       = opcodes[3];
  assign w_link     = opcodes[4];
  assign w_compare  = (w_cmd[3:2] == 2'b10);
  assign w_flag_upd = opcodes[0] | w_compare;

  always_comb begin
    w_logical = 1'b0;
    case (w_cmd)
      4'b0000, 4'b0001, 4'b1000, 4'b1001,
      4'b1100, 4'b1101, 4'b1110, 4'b1111: w_logical = 1'b1;
      default:                            w_logical = 1'b0;
    endcase
  end

  assign {w_n, w_z, w_c, w_v} = r_flags;

  always_comb begin
    w_cond_full = 1'b0;
    case (condicion)
      4'b0000: w_cond_full = w_z;
      4'b0001: w_cond_full = !w_z;
      4'b0010: w_cond_full = w_c;
      4'b0011: w_cond_full = !w_c;
      4'b0100: w_cond_full = w_n;
      4'b0101: w_cond_full = !w_n;
      4'b0110: w_cond_full = w_v;
      4'b0111: w_cond_full = !w_v;
      4'b1000: w_cond_full = w_c & !w_z;
      4'b1001: w_cond_full = !w_c | w_z;
      4'b1010: w_cond_full = (w_n == w_v);
      4'b1011: w_cond_full = (w_n != w_v);
      4'b1100: w_cond_full = !w_z & (w_n == w_v);
      4'b1101: w_cond_full = w_z | (w_n != w_v);
      4'b1110: w_cond_full = 1'b1;
      default: w_cond_full = 1'b0;
    endcase
  end

  // Legacy mode: only branches are conditional, and only on EQ/NE.
  always_comb begin
    w_cond_ok = 1'b1;
    if (COND_FULL != 0) begin
      w_cond_ok = w_cond_full;
    end else if (w_is_br) begin
      w_cond_ok = (condicion == 4'b0000) ? w_z :
                  (condicion == 4'b0001) ? !w_z : 1'b0;
    end
  end

  assign w_timeout = (MEM_TIMEOUT > 0) && !memReady && (r_to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags     <= FLAGS_RST;
      r_cond_pass <= 1'b0;
      r_mem_err   <= 1'b0;
      r_to_cnt    <= '0;
    end else begin
      if (r_state == S_DECODE) begin
        r_cond_pass <= w_cond_ok;
      end
      if ((r_state == S_EXECUTE) && w_is_dp && w_flag_upd) begin
        r_flags <= {aluFlags[3:2], w_logical ? r_flags[1:0] : aluFlags[1:0]};
      end
      if ((r_state == S_MEM) && !memReady && (MEM_TIMEOUT > 0)) begin
        if (w_timeout) begin
          r_mem_err <= 1'b1;
          r_to_cnt  <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:   w_next = instrValid ? S_DECODE : S_FETCH;
      S_DECODE:  w_next = (!w_cond_ok || w_is_undef) ? S_FETCH : S_EXECUTE;
      S_EXECUTE: begin
        if (w_is_dp) begin
          w_next = w_compare ? S_FETCH : S_WB;
        end else if (w_is_mem) begin
          w_next = S_MEM;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_MEM: begin
        if (memReady) begin
          w_next = w_load ? S_WB : S_FETCH;
        end else begin
          w_next = w_timeout ? S_FETCH : S_MEM;
        end
      end
      S_WB:      w_next = S_FETCH;
      default:   w_next = S_FETCH;
    endcase
  end

  always_comb begin
    irWr             = 1'b0;
    pcWr             = 1'b0;
    selPC            = 1'b0;
    regWe            = 1'b0;
    selAddA          = 1'b0;
    selAddB          = 1'b0;
    selAddWr         = 1'b0;
    opALU            = 4'b0000;
    cin              = 1'b0;
    selDiWr          = 2'b00;
    selOperaB        = 1'b0;
    memReq           = 1'b0;
    memWe            = 1'b0;
    logicalOperation = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (instrValid) begin
          irWr = 1'b1;
          pcWr = 1'b1;
        end
      end
      S_EXECUTE: begin
        if (w_is_dp) begin
          opALU            = w_cmd;
          cin              = (w_cmd == 4'b0010);
          selOperaB        = opcodes[5];
          logicalOperation = w_logical;
        end else if (w_is_mem) begin
          selAddA = 1'b1;
          selAddB = 1'b1;
          opALU   = w_up ? 4'b0100 : 4'b0010;
        end else if (w_is_br) begin
          pcWr  = 1'b1;
          selPC = 1'b1;
          if (w_link) begin
            regWe    = 1'b1;
            selAddWr = 1'b1;
            selDiWr  = 2'b11;
          end
        end
      end
      S_MEM: begin
        selAddA = 1'b1;
        selAddB = 1'b1;
        opALU   = w_up ? 4'b0100 : 4'b0010;
        memReq  = 1'b1;
        memWe   = !w_load;
      end
      S_WB: begin
        regWe = 1'b1;
        if (w_is_mem) begin
          selDiWr = 2'b10;
        end else begin
          selDiWr          = (w_cmd == 4'b1101) ? 2'b01 : 2'b00;
          opALU            = w_cmd;
          cin              = (w_cmd == 4'b0010);
          selOperaB        = opcodes[5];
          logicalOperation = w_logical;
        end
      end
      default: begin
      end
    endcase
    // Reset aborts whatever is in flight without a final write.
    if (rst) begin
      irWr   = 1'b0;
      pcWr   = 1'b0;
      regWe  = 1'b0;
      memReq = 1'b0;
      memWe  = 1'b0;
    end
  end

  assign flags    = r_flags;
  assign condPass = r_cond_pass;
  assign memErr   = r_mem_err;

endmodule

// File: tb/tb_control_unit_mc.sv
// tb/tb_control_unit_mc.sv - self-checking bench for control_unit_mc
`timescale 1ns/1ps
module tb_control_unit_mc;

  localparam int PH_F = 0;
  localparam int PH_D = 1;
  localparam int PH_E = 2;
  localparam int PH_M = 3;
  localparam int PH_W = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       instrValid;
  logic [5:0] opcodes;
  logic [1:0] operation;
  logic [3:0] condicion;
  logic [3:0] aluFlags;
  logic       memReady;

  wire [23:0] a_bus;
  wire [23:0] l_bus;
  logic       use_leg;
  wire [23:0] o_bus = use_leg ? l_bus : a_bus;

  wire       o_irWr     = o_bus[23];
  wire       o_pcWr     = o_bus[22];
  wire       o_selPC    = o_bus[21];
  wire       o_regWe    = o_bus[20];
  wire       o_selAddA  = o_bus[19];
  wire       o_selAddB  = o_bus[18];
  wire       o_selAddWr = o_bus[17];
  wire [3:0] o_opALU    = o_bus[16:13];
  wire       o_cin      = o_bus[12];
  wire [1:0] o_selDiWr  = o_bus[11:10];
  wire       o_selOperaB = o_bus[9];
  wire       o_memReq   = o_bus[8];
  wire       o_memWe    = o_bus[7];
  wire       o_logical  = o_bus[6];
  wire [3:0] o_flags    = o_bus[5:2];
  wire       o_condPass = o_bus[1];
  wire       o_memErr   = o_bus[0];
  wire [4:0] o_str      = {o_irWr, o_pcWr, o_regWe, o_memReq, o_memWe};

  control_unit_mc #(.COND_FULL(1), .FLAGS_RST(4'b0000), .MEM_TIMEOUT(4), .TO_W(8)) dut_main (
    .clk(clk), .rst(rst), .instrValid(instrValid), .opcodes(opcodes), .operation(operation),
    .condicion(condicion), .aluFlags(aluFlags), .memReady(memReady),
    .irWr(a_bus[23]), .pcWr(a_bus[22]), .selPC(a_bus[21]), .regWe(a_bus[20]),
    .selAddA(a_bus[19]), .selAddB(a_bus[18]), .selAddWr(a_bus[17]), .opALU(a_bus[16:13]),
    .cin(a_bus[12]), .selDiWr(a_bus[11:10]), .selOperaB(a_bus[9]), .memReq(a_bus[8]),
    .memWe(a_bus[7]), .logicalOperation(a_bus[6]), .flags(a_bus[5:2]),
    .condPass(a_bus[1]), .memErr(a_bus[0])
  );

  control_unit_mc #(.COND_FULL(0), .FLAGS_RST(4'b0100), .MEM_TIMEOUT(0), .TO_W(8)) dut_leg (
    .clk(clk), .rst(rst), .instrValid(instrValid), .opcodes(opcodes), .operation(operation),
    .condicion(condicion), .aluFlags(aluFlags), .memReady(memReady),
    .irWr(l_bus[23]), .pcWr(l_bus[22]), .selPC(l_bus[21]), .regWe(l_bus[20]),
    .selAddA(l_bus[19]), .selAddB(l_bus[18]), .selAddWr(l_bus[17]), .opALU(l_bus[16:13]),
    .cin(l_bus[12]), .selDiWr(l_bus[11:10]), .selOperaB(l_bus[9]), .memReq(l_bus[8]),
    .memWe(l_bus[7]), .logicalOperation(l_bus[6]), .flags(l_bus[5:2]),
    .condPass(l_bus[1]), .memErr(l_bus[0])
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state and the parameters of the DUT currently observed.
  logic [3:0] m_flags;
  logic       m_pass;
  logic       m_err;
  bit         m_leg;
  int         m_to;
  logic [3:0] m_frst;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Even codes test a base predicate, odd codes its inverse; 1111 is the inverse of "always".
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f,
                                    input logic [1:0] op, input bit legacy);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    if (legacy) return (op == 2'b10) ? ((c == 4'd0 && z) || (c == 4'd1 && !z)) : 1'b1;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instrValid = 1'b0;
    memReady = 1'b0;
    @(negedge clk);
    chk("rst_strobes", o_str, 5'b0);
    tick();
    rst = 1'b0;
    m_flags = m_frst;
    m_pass = 1'b0;
    m_err = 1'b0;
    @(negedge clk);
    chk("rst_flags", o_flags, m_frst);
    chk("rst_condPass", o_condPass, 1'b0);
    chk("rst_memErr", o_memErr, 1'b0);
    chk("rst_idle_strobes", o_str, 5'b0);
    chk("rst_opALU", o_opALU, 4'b0);
    chk("rst_selDiWr", o_selDiWr, 2'b0);
    tick();
  endtask

  task automatic run_instr(input logic [1:0] op, input logic [5:0] opc, input logic [3:0] cond,
                           input logic [3:0] alu, input int delay, input int idle, input int rst_at);
    int ph[$];
    int midx;
    logic pass;
    logic tmo;
    logic [3:0] cmd;
    logic [4:0] es;
    cmd = opc[4:1];
    opcodes = opc;
    operation = op;
    condicion = cond;
    aluFlags = alu;
    memReady = 1'b0;
    for (int k = 0; k < idle; k++) begin
      instrValid = 1'b0;
      @(negedge clk);
      chk("idle_strobes", o_str, 5'b0);
      tick();
    end
    pass = ref_cond(cond, m_flags, op, m_leg);
    ph = {PH_F, PH_D};
    tmo = 1'b0;
    if (pass && op != 2'b11) begin
      ph.push_back(PH_E);
      if (op == 2'b01) begin
        if (m_to > 0 && delay >= m_to) begin
          tmo = 1'b1;
          repeat (m_to) ph.push_back(PH_M);
        end else begin
          repeat (delay + 1) ph.push_back(PH_M);
          if (opc[0]) ph.push_back(PH_W);
        end
      end else if (op == 2'b00 && cmd[3:2] != 2'b10) begin
        ph.push_back(PH_W);
      end
    end
    midx = 0;
    foreach (ph[i]) begin
      if (i == rst_at) begin
        rst = 1'b1;
        instrValid = 1'b0;
        memReady = 1'b0;
        @(negedge clk);
        chk("abort_strobes", o_str, 5'b0);
        tick();
        rst = 1'b0;
        m_flags = m_frst;
        m_pass = 1'b0;
        m_err = 1'b0;
        return;
      end
      instrValid = (ph[i] == PH_F);
      memReady = (ph[i] == PH_M) && (midx == delay);
      @(negedge clk);
      es = 5'b0;
      case (ph[i])
        PH_F: begin
          es = 5'b11000;
          chk("F_selPC", o_selPC, 1'b0);
          chk("F_flags", o_flags, m_flags);
          chk("F_condPass", o_condPass, m_pass);
          chk("F_memErr", o_memErr, m_err);
        end
        PH_E: begin
          if (op == 2'b00) begin
            chk("E_opALU", o_opALU, cmd);
            chk("E_cin", o_cin, cmd == 4'b0010);
            chk("E_selOperaB", o_selOperaB, opc[5]);
            chk("E_logical", o_logical, cmd inside {4'd0, 4'd1, 4'd8, 4'd9, 4'd12, 4'd13, 4'd14, 4'd15});
          end else if (op == 2'b01) begin
            chk("E_selAddA", o_selAddA, 1'b1);
            chk("E_selAddB", o_selAddB, 1'b1);
            chk("E_opALU_mem", o_opALU, opc[3] ? 4'b0100 : 4'b0010);
          end else begin
            es = {1'b0, 1'b1, opc[4], 2'b00};
            chk("E_selPC", o_selPC, 1'b1);
            if (opc[4]) begin
              chk("E_selAddWr", o_selAddWr, 1'b1);
              chk("E_selDiWr", o_selDiWr, 2'b11);
            end
          end
        end
        PH_M: begin
          es = {3'b000, 1'b1, !opc[0]};
          chk("M_selAddA", o_selAddA, 1'b1);
        end
        PH_W: begin
          es = 5'b00100;
          chk("W_selDiWr", o_selDiWr, (op == 2'b01) ? 2'b10 : ((cmd == 4'b1101) ? 2'b01 : 2'b00));
        end
        default: es = 5'b0;
      endcase
      chk($sformatf("strobes_ph%0d_c%0d", ph[i], i), o_str, es);
      if (ph[i] == PH_M) midx++;
      if (ph[i] == PH_D) m_pass = pass;
      if (ph[i] == PH_E && op == 2'b00 && (opc[0] || cmd[3:2] == 2'b10)) begin
        m_flags[3:2] = alu[3:2];
        if (!(cmd inside {4'd0, 4'd1, 4'd8, 4'd9, 4'd12, 4'd13, 4'd14, 4'd15}))
          m_flags[1:0] = alu[1:0];
      end
      tick();
    end
    if (tmo) m_err = 1'b1;
    instrValid = 1'b0;
    memReady = 1'b0;
  endtask

  initial begin
    logic [1:0] r_op;
    rst = 1'b1;
    instrValid = 1'b0;
    memReady = 1'b0;
    opcodes = '0;
    operation = '0;
    condicion = '0;
    aluFlags = '0;
    use_leg = 1'b0;
    m_leg = 1'b0;
    m_to = 4;
    m_frst = 4'b0000;
    tick();
    do_reset();

    run_instr(2'b00, 6'b001001, 4'hE, 4'b0011, 0, 0, -1); // ADDS
    run_instr(2'b00, 6'b010101, 4'hE, 4'b0100, 0, 1, -1); // CMP
    run_instr(2'b10, 6'b010000, 4'h0, 4'b1111, 0, 0, -1); // BL EQ
    run_instr(2'b00, 6'b001001, 4'hE, 4'b1000, 0, 0, -1); // ADDS -> N
    run_instr(2'b00, 6'b101001, 4'hA, 4'b0111, 0, 0, -1); // GE fails
    run_instr(2'b01, 6'b001001, 4'hE, 4'b0000, 3, 0, -1); // LDR, ready on last allowed cycle
    run_instr(2'b01, 6'b001000, 4'hE, 4'b0000, 9, 0, -1); // STR timeout
    run_instr(2'b00, 6'b011010, 4'hE, 4'b0000, 0, 2, -1); // MOV
    run_instr(2'b01, 6'b000001, 4'hE, 4'b0000, 0, 0, -1); // LDR down
    run_instr(2'b11, 6'b000000, 4'hE, 4'b0000, 0, 0, -1); // undefined

    for (int n = 0; n < 40; n++) begin
      r_op = 2'($urandom_range(0, 3));
      run_instr(r_op, 6'($urandom), 4'($urandom), 4'($urandom),
                int'($urandom_range(0, 5)), int'($urandom_range(0, 2)), -1);
    end

    use_leg = 1'b1;
    m_leg = 1'b1;
    m_to = 0;
    m_frst = 4'b0100;
    do_reset();
    run_instr(2'b00, 6'b001001, 4'hF, 4'b1011, 0, 0, -1); // DP on cond 1111 runs
    run_instr(2'b00, 6'b001001, 4'hE, 4'b0000, 0, 0, -1); // clear Z
    run_instr(2'b10, 6'b010000, 4'hA, 4'b0000, 0, 0, -1); // GE branch not taken
    run_instr(2'b10, 6'b000000, 4'h1, 4'b0000, 0, 0, -1); // BNE taken
    run_instr(2'b10, 6'b000000, 4'h0, 4'b0000, 0, 0, -1); // BEQ not taken
    run_instr(2'b01, 6'b001001, 4'h3, 4'b0000, 6, 0, -1); // LDR long wait, no timeout
    run_instr(2'b01, 6'b001000, 4'hE, 4'b0000, 20, 0, 4); // STR aborted mid-MEM
    run_instr(2'b10, 6'b010000, 4'h0, 4'b0000, 0, 1, -1); // BEQ after reset: Z restored
    run_instr(2'b00, 6'b000100, 4'h5, 4'b1111, 0, 0, -1); // SUB, no flag write

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
